// File: rtl/nn_pkg.sv
// Shared state encoding and default Q-format widths for the neuron datapath.
package nn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACCUM,
        BIAS,
        SAT,
        OUT
    } mac_state_t;

    localparam int SAT_LATENCY        = 2;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_FRAC_BITS  = 8;
    localparam int DEFAULT_ACC_WIDTH  = 40;
    localparam int DEFAULT_NUM_INPUTS = 8;

endpackage

// File: rtl/overflow_underflow_rectifier.sv
// Two-stage saturation: clamps a wide signed value into the narrow signed range.
// Deliberately reset-free; the owner gates the output while it is not meaningful.
module overflow_underflow_rectifier #(
    parameter int UNRECTIFIED_DATA_WIDTH = 40,
    parameter int RECTIFIED_DATA_WIDTH   = 16
) (
    input  logic                                     clk,
    input  logic signed [UNRECTIFIED_DATA_WIDTH-1:0] unrectified,
    output logic signed [RECTIFIED_DATA_WIDTH-1:0]   rectified
);

    localparam int PAD = UNRECTIFIED_DATA_WIDTH - RECTIFIED_DATA_WIDTH + 1;

    localparam logic signed [UNRECTIFIED_DATA_WIDTH-1:0] MAX_VAL =
        {{PAD{1'b0}}, {(RECTIFIED_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [UNRECTIFIED_DATA_WIDTH-1:0] MIN_VAL =
        {{PAD{1'b1}}, {(RECTIFIED_DATA_WIDTH-1){1'b0}}};

    logic signed [RECTIFIED_DATA_WIDTH-1:0] clamp_d;
    logic signed [RECTIFIED_DATA_WIDTH-1:0] stage1;
    logic signed [RECTIFIED_DATA_WIDTH-1:0] stage2;

    // Clamp the wide value to the representable narrow range.
    always_comb begin
        if (unrectified > MAX_VAL) begin
            clamp_d = MAX_VAL[RECTIFIED_DATA_WIDTH-1:0];
        end else if (unrectified < MIN_VAL) begin
            clamp_d = MIN_VAL[RECTIFIED_DATA_WIDTH-1:0];
        end else begin
            clamp_d = unrectified[RECTIFIED_DATA_WIDTH-1:0];
        end
    end

    // Two pipeline registers give the stage its fixed two-edge latency.
    always_ff @(posedge clk) begin
        stage1 <= clamp_d;
        stage2 <= stage1;
    end

    assign rectified = stage2;

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Sequences one neuron evaluation: accumulate x*w beats, add bias, rescale,
// saturate, and present the result on a valid/ready output.
module neuron_mac_sequencer
    import nn_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FRAC_BITS  = DEFAULT_FRAC_BITS,
    parameter int ACC_WIDTH  = DEFAULT_ACC_WIDTH,
    parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS
) (
    input  logic                                clk_in,
    input  logic                                rst_n_in,
    input  logic signed [DATA_WIDTH-1:0]        x_in,
    input  logic signed [DATA_WIDTH-1:0]        w_in,
    input  logic signed [DATA_WIDTH-1:0]        bias_in,
    input  logic                                in_valid_in,
    output logic                                in_ready_out,
    input  logic                                abort_in,
    output logic signed [DATA_WIDTH-1:0]        y_out,
    output logic                                out_valid_out,
    input  logic                                out_ready_in,
    output logic                                busy_out,
    output logic [$clog2(NUM_INPUTS+1)-1:0]     count_out
);

    localparam int CNT_W     = $clog2(NUM_INPUTS + 1);
    localparam int SAT_CNT_W = (SAT_LATENCY > 1) ? $clog2(SAT_LATENCY) : 1;

    logic [1:0]                     rst_sync;
    logic                           rst_n;
    mac_state_t                     state, state_d;
    logic signed [ACC_WIDTH-1:0]    acc, acc_d;
    logic [CNT_W-1:0]               count, count_d;
    logic signed [DATA_WIDTH-1:0]   bias_q, bias_d;
    logic [SAT_CNT_W-1:0]           sat_cnt, sat_cnt_d;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    sat_in;
    logic signed [DATA_WIDTH-1:0]   sat_y;
    logic                           beat;

    // Reset asserts asynchronously but releases only after two clock edges.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n  = rst_sync[1];
    assign prod   = x_in * w_in;
    assign sat_in = acc >>> FRAC_BITS;
    assign beat   = in_valid_in && in_ready_out;

    overflow_underflow_rectifier #(
        .UNRECTIFIED_DATA_WIDTH(ACC_WIDTH),
        .RECTIFIED_DATA_WIDTH  (DATA_WIDTH)
    ) u_rectifier (
        .clk        (clk_in),
        .unrectified(sat_in),
        .rectified  (sat_y)
    );

    // State, accumulator, beat counter, bias and saturation-wait registers.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            bias_q  <= '0;
            sat_cnt <= '0;
        end else begin
            state   <= state_d;
            acc     <= acc_d;
            count   <= count_d;
            bias_q  <= bias_d;
            sat_cnt <= sat_cnt_d;
        end
    end

    // Next-state, datapath updates and handshake outputs; abort overrides everything.
    always_comb begin
        state_d      = state;
        acc_d        = acc;
        count_d      = count;
        bias_d       = bias_q;
        sat_cnt_d    = sat_cnt;
        in_ready_out = (state == ACCUM) && !abort_in;

        if (abort_in && (state != IDLE)) begin
            state_d   = ACCUM;
            acc_d     = '0;
            count_d   = '0;
            sat_cnt_d = '0;
        end else begin
            case (state)
                IDLE: state_d = ACCUM;
                ACCUM: begin
                    if (beat) begin
                        if (count == '0) begin
                            acc_d  = ACC_WIDTH'(prod);
                            bias_d = bias_in;
                        end else begin
                            acc_d = acc + ACC_WIDTH'(prod);
                        end
                        count_d = count + CNT_W'(1);
                        if (count == CNT_W'(NUM_INPUTS - 1)) begin
                            state_d = BIAS;
                        end
                    end
                end
                BIAS: begin
                    acc_d     = acc + (ACC_WIDTH'(bias_q) <<< FRAC_BITS);
                    sat_cnt_d = '0;
                    state_d   = SAT;
                end
                SAT: begin
                    sat_cnt_d = sat_cnt + SAT_CNT_W'(1);
                    if (sat_cnt == SAT_CNT_W'(SAT_LATENCY - 1)) begin
                        state_d = OUT;
                    end
                end
                OUT: begin
                    if (out_ready_in) begin
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ACCUM;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign out_valid_out = (state == OUT);
    assign y_out         = (state == OUT) ? sat_y : '0;
    assign busy_out      = !((state == IDLE) || ((state == ACCUM) && (count == '0)));
    assign count_out     = count;

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Self-checking bench: directed scenarios plus randomized evaluations against
// an arithmetic reference model of the neuron.
module tb_neuron_mac_sequencer;

    localparam int DW = 16;
    localparam int FB = 8;
    localparam int AW = 40;
    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);
    localparam longint YMAX = (longint'(1) <<< (DW - 1)) - 1;
    localparam longint YMIN = -(longint'(1) <<< (DW - 1));

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic signed [DW-1:0] x, w, bias;
    logic                 in_valid, in_ready, abort;
    logic signed [DW-1:0] y;
    logic                 out_valid, out_ready, busy;
    logic [CW-1:0]        count;

    int n_tests = 0;
    int n_fail  = 0;

    logic signed [DW-1:0] xs [N];
    logic signed [DW-1:0] ws [N];
    logic signed [DW-1:0] bias0;

    always #5 clk = ~clk;

    neuron_mac_sequencer #(
        .DATA_WIDTH(DW),
        .FRAC_BITS (FB),
        .ACC_WIDTH (AW),
        .NUM_INPUTS(N)
    ) dut (
        .clk_in       (clk),
        .rst_n_in     (rst_n),
        .x_in         (x),
        .w_in         (w),
        .bias_in      (bias),
        .in_valid_in  (in_valid),
        .in_ready_out (in_ready),
        .abort_in     (abort),
        .y_out        (y),
        .out_valid_out(out_valid),
        .out_ready_in (out_ready),
        .busy_out     (busy),
        .count_out    (count)
    );

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Dot product plus bias in real-number terms, floored back to the Q grid, then clamped.
    function automatic longint ref_y();
        longint s = 0;
        for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(ws[i]);
        s += longint'(bias0) * (longint'(1) <<< FB);
        s = s >>> FB;
        if (s > YMAX) s = YMAX;
        if (s < YMIN) s = YMIN;
        return s;
    endfunction

    task automatic set_arrays(input logic signed [DW-1:0] xv, input logic signed [DW-1:0] wv,
                              input logic signed [DW-1:0] bv);
        for (int i = 0; i < N; i++) begin
            xs[i] = xv;
            ws[i] = wv;
        end
        bias0 = bv;
    endtask

    // Present beats at negedges; a beat counts when valid meets ready at the next posedge.
    task automatic feed(input int n, input bit gaps);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 500) begin
            @(negedge clk);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            x = xs[k];
            w = ws[k];
            if (k == 0) bias = bias0;
            else        bias = DW'($urandom);
            if (in_valid && in_ready) k++;
            guard++;
        end
        check("feed_beats", k, n);
    endtask

    task automatic get_result(input logic signed [63:0] exp, input int stall);
        int k = 0;
        out_ready = (stall == 0);
        do begin
            @(negedge clk);
            in_valid = 1'b0;
            k++;
        end while (!out_valid && k < 50);
        check("latency_edges", k - 1, 3);
        check("y_value", y, exp);
        check("busy_in_out", busy, 1);
        check("count_full", count, N);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_y", y, exp);
            check("stall_in_ready", in_ready, 0);
            check("stall_count", count, N);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("valid_one_cycle", out_valid, 0);
        check("y_gated", y, 0);
        check("count_cleared", count, 0);
        check("ready_after_out", in_ready, 1);
        check("busy_after_out", busy, 0);
    endtask

    task automatic release_reset();
        int k = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_ready", in_ready, 0);
        check("idle_not_busy", busy, 0);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("reach_accum", in_ready, 1);
    endtask

    initial begin
        rst_n = 1'b1; x = '0; w = '0; bias = '0;
        in_valid = 1'b0; abort = 1'b0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 0);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        repeat (3) @(negedge clk);
        release_reset();

        // Basic
        set_arrays(16'sh0100, 16'sh0200, 16'sh0000);
        feed(N, 1'b0);
        get_result(64'sd4096, 0);

        // Positive and negative saturation
        set_arrays(16'sh7FFF, 16'sh7FFF, 16'sh7FFF);
        feed(N, 1'b0);
        get_result(64'sd32767, 0);
        set_arrays(16'sh8000, 16'sh7FFF, 16'sh0000);
        feed(N, 1'b0);
        get_result(-64'sd32768, 0);

        // Bias-only path; later beats carry random bias_in
        set_arrays(16'sh0000, 16'sh0000, 16'shFF00);
        feed(N, 1'b0);
        get_result(-64'sd256, 0);

        // Backpressure
        set_arrays(16'sh0100, 16'sh0200, 16'sh0000);
        feed(N, 1'b0);
        get_result(64'sd4096, 10);

        // Abort after three beats, with a beat offered in the abort cycle
        feed(3, 1'b0);
        @(negedge clk);
        check("pre_abort_count", count, 3);
        in_valid = 1'b1;
        abort = 1'b1;
        #1;
        check("abort_blocks_ready", in_ready, 0);
        check("abort_busy", busy, 1);
        @(negedge clk);
        abort = 1'b0;
        in_valid = 1'b0;
        #1;
        check("abort_count", count, 0);
        check("abort_not_busy", busy, 0);
        check("abort_ready", in_ready, 1);
        feed(N, 1'b1);
        get_result(64'sd4096, 0);

        // Reset during SAT
        feed(N, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y", y, 0);
        check("midrst_busy", busy, 0);
        check("midrst_count", count, 0);
        repeat (2) @(negedge clk);
        release_reset();
        feed(N, 1'b0);
        get_result(64'sd4096, 0);

        // Randomized evaluations
        for (int t = 0; t < 15; t++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) != 0) begin
                    xs[i] = DW'(int'($urandom_range(0, 2047)) - 1024);
                    ws[i] = DW'(int'($urandom_range(0, 2047)) - 1024);
                end else begin
                    xs[i] = DW'($urandom);
                    ws[i] = DW'($urandom);
                end
            end
            bias0 = ($urandom_range(0, 1) != 0) ? DW'(int'($urandom_range(0, 4095)) - 2048) : DW'($urandom);
            feed(N, $urandom_range(0, 1) != 0);
            get_result(ref_y(), int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
